// File: rtl/spi_master.sv
// SPI master for 7-bit address, R/W flag and one data byte (16 SCLK cycles, mode 0).
// One state register drives registered pin outputs; SCLK comes from a HALF_PERIOD down-counter.
`timescale 1ns/1ps
module spi_master #(
   parameter int HALF_PERIOD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       sclk_pin,
   output logic       cs_pin,
   output logic       mosi_pin,
   input  logic       miso_pin
);

   localparam logic [7:0] DIV_RELOAD = 8'(HALF_PERIOD - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

   state_e      state_q;
   logic [7:0]  div_q;
   logic [3:0]  bit_q;
   logic        phase_q;
   logic [15:0] tx_q;
   logic [7:0]  rx_q;
   logic        rw_q;
   logic        busy_q, done_q, sclk_q, cs_q, mosi_q;
   logic [7:0]  rdata_q;

   // NOTE: non-blocking assignments only; every branch reads the pre-edge register values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         rw_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         cs_q    <= 1'b1;
         mosi_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  tx_q    <= {addr, rw, (rw ? 8'h00 : wdata)};
                  rw_q    <= rw;
                  busy_q  <= 1'b1;
                  cs_q    <= 1'b0;
                  div_q   <= DIV_RELOAD;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (div_q == 8'd0) begin
                  mosi_q  <= tx_q[15];
                  tx_q    <= {tx_q[14:0], 1'b0};
                  bit_q   <= 4'd0;
                  phase_q <= 1'b0;
                  div_q   <= DIV_RELOAD;
                  state_q <= SHIFT;
               end else begin
                  div_q <= div_q - 8'd1;
               end
            end
            SHIFT: begin
               if (div_q != 8'd0) begin
                  div_q <= div_q - 8'd1;
               end else if (!phase_q) begin
                  // Rising SCLK edge: the slave's bit has been stable for the whole low phase.
                  sclk_q  <= 1'b1;
                  phase_q <= 1'b1;
                  div_q   <= DIV_RELOAD;
                  if (rw_q && bit_q[3]) rx_q <= {rx_q[6:0], miso_pin};
               end else if (bit_q == 4'd15) begin
                  sclk_q  <= 1'b0;
                  div_q   <= DIV_RELOAD;
                  state_q <= HOLD;
               end else begin
                  sclk_q  <= 1'b0;
                  phase_q <= 1'b0;
                  bit_q   <= bit_q + 4'd1;
                  mosi_q  <= tx_q[15];
                  tx_q    <= {tx_q[14:0], 1'b0};
                  div_q   <= DIV_RELOAD;
               end
            end
            HOLD: begin
               if (div_q == 8'd0) begin
                  cs_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  mosi_q  <= 1'b0;
                  if (rw_q) rdata_q <= rx_q;
                  state_q <= DONE;
               end else begin
                  div_q <= div_q - 8'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign sclk_pin = sclk_q;
   assign cs_pin   = cs_q;
   assign mosi_pin = mosi_q;

endmodule
